// File: rtl/tri_wave_counter_if.sv
// Control/status bundle for tri_wave_counter: configuration strobes in, count state out.
interface tri_wave_counter_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
);
  logic               ena;
  logic [1:0]         mode;
  logic               load;
  logic [1:0]         load_sel;
  logic [WIDTH-1:0]   load_data;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   count;
  logic               dir;
  logic               tc;

  modport master (
    output ena, mode, load, load_sel, load_data, presc,
    input  count, dir, tc
  );

  modport slave (
    input  ena, mode, load, load_sel, load_data, presc,
    output count, dir, tc
  );
endinterface

// File: rtl/tri_wave_counter.sv
// Programmable up/down/triangle counter with bounds, step and tick prescaler.
// Count, dir and tc are registered: a tick on edge N is visible right after edge N.
module tri_wave_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  tri_wave_counter_if.slave  bus
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [1:0] SEL_COUNT = 2'b00;
  localparam logic [1:0] SEL_LO    = 2'b01;
  localparam logic [1:0] SEL_HI    = 2'b10;

  localparam logic [WIDTH-1:0]   STEP_ONE  = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  logic [WIDTH-1:0]   r_count;
  logic               r_dir;
  logic               r_tc;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_step;
  logic [PRESC_W-1:0] r_presc_cnt;

  logic               w_tick;
  logic               w_degen;
  logic [WIDTH:0]     w_step;
  logic [WIDTH:0]     w_cnt_x;
  logic [WIDTH:0]     w_lo_x;
  logic [WIDTH:0]     w_hi_x;
  logic [WIDTH:0]     w_up_sum;
  logic [WIDTH:0]     w_dn_diff;
  logic [WIDTH:0]     w_lo_step;
  logic [WIDTH-1:0]   w_nxt_count;
  logic               w_nxt_dir;
  logic               w_nxt_tc;

  assign w_tick    = bus.ena && (r_presc_cnt == bus.presc);
  // Widened by one bit so bound checks see true sums instead of wrapped ones.
  assign w_step    = {1'b0, (r_step == '0) ? STEP_ONE : r_step};
  assign w_cnt_x   = {1'b0, r_count};
  assign w_lo_x    = {1'b0, r_lo};
  assign w_hi_x    = {1'b0, r_hi};
  assign w_up_sum  = w_cnt_x + w_step;
  assign w_dn_diff = w_cnt_x - w_step;
  assign w_lo_step = w_lo_x + w_step;
  assign w_degen   = (r_lo >= r_hi);

  always_comb begin
    w_nxt_count = r_count;
    w_nxt_dir   = r_dir;
    w_nxt_tc    = 1'b0;
    if (w_tick && bus.mode != MODE_HOLD) begin
      if (w_degen) begin
        w_nxt_count = r_lo;
        w_nxt_dir   = 1'b1;
      end else begin
        case (bus.mode)
          MODE_UP: begin
            w_nxt_dir = 1'b1;
            if (w_up_sum > w_hi_x) begin
              w_nxt_count = r_lo;
              w_nxt_tc    = 1'b1;
            end else begin
              w_nxt_count = w_up_sum[WIDTH-1:0];
            end
          end
          MODE_DOWN: begin
            w_nxt_dir = 1'b0;
            if (w_cnt_x < w_lo_step) begin
              w_nxt_count = r_hi;
              w_nxt_tc    = 1'b1;
            end else begin
              w_nxt_count = w_dn_diff[WIDTH-1:0];
            end
          end
          MODE_TRI: begin
            if (r_dir) begin
              if (w_up_sum >= w_hi_x) begin
                w_nxt_count = r_hi;
                w_nxt_dir   = 1'b0;
                w_nxt_tc    = 1'b1;
              end else begin
                w_nxt_count = w_up_sum[WIDTH-1:0];
              end
            end else begin
              if (w_cnt_x <= w_lo_step) begin
                w_nxt_count = r_lo;
                w_nxt_dir   = 1'b1;
                w_nxt_tc    = 1'b1;
              end else begin
                w_nxt_count = w_dn_diff[WIDTH-1:0];
              end
            end
          end
          default: begin
            w_nxt_count = r_count;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_dir       <= 1'b1;
      r_tc        <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '1;
      r_step      <= STEP_ONE;
      r_presc_cnt <= '0;
    end else begin
      if (bus.load && bus.load_sel == SEL_COUNT) begin
        r_presc_cnt <= '0;
      end else if (bus.ena) begin
        r_presc_cnt <= (r_presc_cnt == bus.presc) ? '0 : r_presc_cnt + PRESC_ONE;
      end

      // A write strobe swallows any tick landing in the same cycle.
      if (bus.load) begin
        r_tc <= 1'b0;
        case (bus.load_sel)
          SEL_COUNT: r_count <= bus.load_data;
          SEL_LO:    r_lo    <= bus.load_data;
          SEL_HI:    r_hi    <= bus.load_data;
          default:   r_step  <= bus.load_data;
        endcase
      end else begin
        r_count <= w_nxt_count;
        r_dir   <= w_nxt_dir;
        r_tc    <= w_nxt_tc;
      end
    end
  end

  assign bus.count = r_count;
  assign bus.dir   = r_dir;
  assign bus.tc    = r_tc;

endmodule

// File: tb/tb_tri_wave_counter.sv
// Directed bench for tri_wave_counter: one task per scenario, inline expected-value checks.
module tb_tri_wave_counter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  tri_wave_counter_if #(.WIDTH(8), .PRESC_W(4)) bus ();

  tri_wave_counter #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [7:0] data);
    bus.load      = 1'b1;
    bus.load_sel  = sel;
    bus.load_data = data;
    @(posedge clk);
    #1;
    bus.load      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.ena       = 1'b1;
    bus.mode      = 2'b00;
    bus.load      = 1'b0;
    bus.load_sel  = 2'b00;
    bus.load_data = 8'd0;
    bus.presc     = 4'd0;
    step_clk(2);
    n_tests++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_tests++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %0b want 1", bus.dir); end
    n_tests++; if (bus.tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %0b want 0", bus.tc); end
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_c;
    for (int k = 1; k <= 257; k++) begin
      step_clk(1);
      exp_c = 8'(k);
      n_tests++; if (bus.count !== exp_c) begin n_fail++; $display("FAIL upwrap_count[%0d]: got %0d want %0d", k, bus.count, exp_c); end
      n_tests++; if (bus.tc !== (k == 256)) begin n_fail++; $display("FAIL upwrap_tc[%0d]: got %0b want %0b", k, bus.tc, (k == 256)); end
      n_tests++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL upwrap_dir[%0d]: got %0b want 1", k, bus.dir); end
    end
  endtask

  task automatic test_triangle();
    int   exp_c[9] = '{13, 16, 19, 20, 17, 14, 11, 10, 13};
    logic exp_t[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    logic exp_d[9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    bus.mode = 2'b10;
    do_load(2'b01, 8'd10);
    do_load(2'b10, 8'd20);
    do_load(2'b11, 8'd3);
    do_load(2'b00, 8'd10);
    n_tests++; if (bus.count !== 8'd10 || bus.tc !== 1'b0) begin n_fail++; $display("FAIL tri_load: got count %0d tc %0b want 10/0", bus.count, bus.tc); end
    for (int i = 0; i < 9; i++) begin
      step_clk(1);
      n_tests++; if (bus.count !== 8'(exp_c[i])) begin n_fail++; $display("FAIL tri_count[%0d]: got %0d want %0d", i, bus.count, exp_c[i]); end
      n_tests++; if (bus.tc !== exp_t[i]) begin n_fail++; $display("FAIL tri_tc[%0d]: got %0b want %0b", i, bus.tc, exp_t[i]); end
      n_tests++; if (bus.dir !== exp_d[i]) begin n_fail++; $display("FAIL tri_dir[%0d]: got %0b want %0b", i, bus.dir, exp_d[i]); end
    end
  endtask

  task automatic test_down_wrap();
    int   exp_c[4] = '{7, 5, 9, 7};
    logic exp_t[4] = '{0, 0, 1, 0};
    bus.mode = 2'b01;
    do_load(2'b01, 8'd5);
    do_load(2'b10, 8'd9);
    do_load(2'b11, 8'd2);
    do_load(2'b00, 8'd9);
    for (int i = 0; i < 4; i++) begin
      step_clk(1);
      n_tests++; if (bus.count !== 8'(exp_c[i])) begin n_fail++; $display("FAIL down_count[%0d]: got %0d want %0d", i, bus.count, exp_c[i]); end
      n_tests++; if (bus.tc !== exp_t[i]) begin n_fail++; $display("FAIL down_tc[%0d]: got %0b want %0b", i, bus.tc, exp_t[i]); end
      n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL down_dir[%0d]: got %0b want 0", i, bus.dir); end
    end
  endtask

  task automatic test_prescaler();
    int exp_c[6] = '{0, 0, 0, 1, 1, 1};
    bus.mode  = 2'b00;
    bus.presc = 4'd3;
    do_load(2'b01, 8'd0);
    do_load(2'b10, 8'd255);
    do_load(2'b11, 8'd1);
    do_load(2'b00, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step_clk(1);
      n_tests++; if (bus.count !== 8'(exp_c[i])) begin n_fail++; $display("FAIL presc_count[%0d]: got %0d want %0d", i, bus.count, exp_c[i]); end
    end
    bus.ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_clk(1);
      n_tests++; if (bus.count !== 8'd1 || bus.tc !== 1'b0) begin n_fail++; $display("FAIL presc_frozen[%0d]: got count %0d tc %0b want 1/0", i, bus.count, bus.tc); end
    end
    bus.ena = 1'b1;
    step_clk(1);
    n_tests++; if (bus.count !== 8'd1) begin n_fail++; $display("FAIL presc_phase_a: got %0d want 1", bus.count); end
    step_clk(1);
    n_tests++; if (bus.count !== 8'd2) begin n_fail++; $display("FAIL presc_phase_b: got %0d want 2", bus.count); end
    step_clk(3);
    do_load(2'b00, 8'd100);
    n_tests++; if (bus.count !== 8'd100 || bus.tc !== 1'b0) begin n_fail++; $display("FAIL presc_load_tick: got count %0d tc %0b want 100/0", bus.count, bus.tc); end
    for (int i = 0; i < 3; i++) begin
      step_clk(1);
      n_tests++; if (bus.count !== 8'd100) begin n_fail++; $display("FAIL presc_after_load[%0d]: got %0d want 100", i, bus.count); end
    end
    step_clk(1);
    n_tests++; if (bus.count !== 8'd101) begin n_fail++; $display("FAIL presc_next_inc: got %0d want 101", bus.count); end
  endtask

  task automatic test_degenerate();
    int   exp_c[4] = '{1, 2, 3, 0};
    logic exp_t[4] = '{0, 0, 0, 1};
    bus.presc = 4'd0;
    bus.mode  = 2'b00;
    do_load(2'b01, 8'd50);
    do_load(2'b10, 8'd50);
    for (int i = 0; i < 5; i++) begin
      step_clk(1);
      n_tests++; if (bus.count !== 8'd50 || bus.tc !== 1'b0) begin n_fail++; $display("FAIL degen[%0d]: got count %0d tc %0b want 50/0", i, bus.count, bus.tc); end
    end
    do_load(2'b11, 8'd0);
    do_load(2'b01, 8'd0);
    do_load(2'b10, 8'd3);
    do_load(2'b00, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step_clk(1);
      n_tests++; if (bus.count !== 8'(exp_c[i])) begin n_fail++; $display("FAIL step0_count[%0d]: got %0d want %0d", i, bus.count, exp_c[i]); end
      n_tests++; if (bus.tc !== exp_t[i]) begin n_fail++; $display("FAIL step0_tc[%0d]: got %0b want %0b", i, bus.tc, exp_t[i]); end
    end
  endtask

  task automatic test_async_reset();
    int   exp_c[6] = '{251, 252, 253, 254, 255, 0};
    logic exp_t[6] = '{0, 0, 0, 0, 0, 1};
    bus.mode = 2'b10;
    do_load(2'b01, 8'd10);
    do_load(2'b10, 8'd20);
    do_load(2'b11, 8'd3);
    do_load(2'b00, 8'd10);
    step_clk(5);
    n_tests++; if (bus.count !== 8'd17 || bus.dir !== 1'b0) begin n_fail++; $display("FAIL pre_reset: got count %0d dir %0b want 17/0", bus.count, bus.dir); end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL async_rst_count: got %0d want 0", bus.count); end
    n_tests++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL async_rst_dir: got %0b want 1", bus.dir); end
    n_tests++; if (bus.tc !== 1'b0) begin n_fail++; $display("FAIL async_rst_tc: got %0b want 0", bus.tc); end
    bus.mode = 2'b00;
    #2;
    rst_n = 1'b1;
    do_load(2'b00, 8'd250);
    n_tests++; if (bus.count !== 8'd250) begin n_fail++; $display("FAIL post_rst_load: got %0d want 250", bus.count); end
    for (int i = 0; i < 6; i++) begin
      step_clk(1);
      n_tests++; if (bus.count !== 8'(exp_c[i])) begin n_fail++; $display("FAIL post_rst_count[%0d]: got %0d want %0d", i, bus.count, exp_c[i]); end
      n_tests++; if (bus.tc !== exp_t[i]) begin n_fail++; $display("FAIL post_rst_tc[%0d]: got %0b want %0b", i, bus.tc, exp_t[i]); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_up_wrap();
    test_triangle();
    test_down_wrap();
    test_prescaler();
    test_degenerate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
